// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the branch resolve unit: funct3 branch
// encodings, fall-through increment and default widths.
package branch_resolve_unit_pkg;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'd0,
    F3_BNE  = 3'd1,
    F3_BLT  = 3'd4,
    F3_BGE  = 3'd5,
    F3_BLTU = 3'd6,
    F3_BGEU = 3'd7
  } branch_f3_e;

  localparam int unsigned FALLTHRU_INC       = 4;
  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 32;
  localparam int unsigned DEFAULT_CNT_WIDTH  = 16;

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluation; funct3 values 2 and 3 are
// reported as illegal and never taken.
module branch_cmp
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] rs1_i,
  input  logic [DATA_WIDTH-1:0] rs2_i,
  input  logic [2:0]            funct3_i,
  output logic                  taken_o,
  output logic                  illegal_o
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (rs1_i == rs2_i);
  assign lt_s = ($signed(rs1_i) < $signed(rs2_i));
  assign lt_u = (rs1_i < rs2_i);

  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (branch_f3_e'(funct3_i))
      F3_BEQ:  taken_o = eq;
      F3_BNE:  taken_o = ~eq;
      F3_BLT:  taken_o = lt_s;
      F3_BGE:  taken_o = ~lt_s;
      F3_BLTU: taken_o = lt_u;
      F3_BGEU: taken_o = ~lt_u;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// One-cycle branch resolver with a single-entry valid/ready output stage and
// saturating handoff statistics.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  input  logic [2:0]            funct3_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic [ADDR_WIDTH-1:0] imm_i,
  input  logic                  pred_taken_i,
  input  logic                  flush_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  taken_o,
  output logic                  mispredict_o,
  output logic                  illegal_o,
  output logic [ADDR_WIDTH-1:0] redirect_pc_o,
  output logic [CNT_WIDTH-1:0]  branch_cnt_o,
  output logic [CNT_WIDTH-1:0]  mispred_cnt_o
);

  logic                  cmp_taken;
  logic                  cmp_illegal;
  logic                  accept;
  logic                  handoff;

  logic                  valid_q,   valid_d;
  logic                  taken_q,   taken_d;
  logic                  mispred_q, mispred_d;
  logic                  illegal_q, illegal_d;
  logic [ADDR_WIDTH-1:0] redir_q,   redir_d;
  logic [CNT_WIDTH-1:0]  bcnt_q,    bcnt_d;
  logic [CNT_WIDTH-1:0]  mcnt_q,    mcnt_d;

  branch_cmp #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_cmp (
    .rs1_i    (rs1_data_i),
    .rs2_i    (rs2_data_i),
    .funct3_i (funct3_i),
    .taken_o  (cmp_taken),
    .illegal_o(cmp_illegal)
  );

  assign in_ready = ~flush_i & (~valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  // A flushed result is dropped, never counted as handed off.
  assign handoff  = valid_q & out_ready & ~flush_i;

  always_comb begin
    valid_d   = valid_q;
    taken_d   = taken_q;
    mispred_d = mispred_q;
    illegal_d = illegal_q;
    redir_d   = redir_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d   = 1'b1;
      taken_d   = cmp_taken;
      illegal_d = cmp_illegal;
      mispred_d = ~cmp_illegal & (cmp_taken ^ pred_taken_i);
      redir_d   = cmp_taken ? (pc_i + imm_i) : (pc_i + ADDR_WIDTH'(FALLTHRU_INC));
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    bcnt_d = bcnt_q;
    mcnt_d = mcnt_q;
    if (handoff && !illegal_q && (bcnt_q != '1)) bcnt_d = bcnt_q + 1'b1;
    if (handoff && mispred_q && (mcnt_q != '1))  mcnt_d = mcnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      taken_q   <= 1'b0;
      mispred_q <= 1'b0;
      illegal_q <= 1'b0;
      redir_q   <= '0;
      bcnt_q    <= '0;
      mcnt_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      taken_q   <= taken_d;
      mispred_q <= mispred_d;
      illegal_q <= illegal_d;
      redir_q   <= redir_d;
      bcnt_q    <= bcnt_d;
      mcnt_q    <= mcnt_d;
    end
  end

  assign out_valid     = valid_q;
  assign taken_o       = taken_q;
  assign mispredict_o  = mispred_q;
  assign illegal_o     = illegal_q;
  assign redirect_pc_o = redir_q;
  assign branch_cnt_o  = bcnt_q;
  assign mispred_cnt_o = mcnt_q;

endmodule
